sha1_core: RTL and testbench
============================

Name: sha1_core

Overview:
- Iterative SHA-1 compression engine. Consumes one 512-bit block from the Wishbone front end (message register plus on/reset control bits) and produces the 160-bit digest that the front end exposes through its digest reads.
- Runs one round per clock: 80 rounds plus one finalisation cycle.
- Reports its round counter, done and panic status for the front end's status register.
- Supports chaining, so multi-block messages can be hashed one block at a time.

Parameters:
- IV, 160'hC3D2E1F0_10325476_98BADCFE_EFCDAB89_67452301: initial hash state, packed with H0 in [31:0] and H4 in [159:128].

Ports:
- wb_clk_i  input  1  clock.
- reset  input  1  synchronous, active-high reset; clock wb_clk_i.
- soft_reset  input  1  single-cycle pulse from the front end's reset bit; same effect as reset.
- start  input  1  level "on" bit; starts a block when high in IDLE.
- chain  input  1  sampled with start: 1 = initial state is current digest_out, 0 = initial state is IV.
- message_in  input  512  block; word W[t] = message_in[32t+31:32t] for t=0..15, each word big-endian as in FIPS 180-4.
- digest_out  output  160  H0 in [31:0] through H4 in [159:128].
- done  output  1  block complete; digest_out valid.
- panic  output  1  sticky abort flag.
- loop_idx  output  7  current round, 0..79.

Behaviour:
- Reset or soft_reset has priority over everything else and sets:
  - state = IDLE
  - digest_out = 0
  - done = 0, panic = 0, loop_idx = 0
  - working registers a..e = 0, schedule buffer = 0
- States:
  - IDLE → ROUND: when start=1. On that edge (edge k):
    - load the 16-word schedule buffer from message_in;
    - load a..e and the H latch from IV, or from digest_out if chain=1;
    - loop_idx = 0; done = 0; panic = 0.
  - ROUND: one round per edge, at edges k+1..k+80, t = loop_idx.
    - W[t]: the buffer word for t<16; for t≥16, W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), using a 16-entry circular buffer indexed t mod 16, with W[t] written back in place.
    - f/K by round:
      - t 0-19: f = (b&c)|(~b&d), K = 5A827999.
      - t 20-39: f = b^c^d, K = 6ED9EBA1.
      - t 40-59: f = (b&c)|(b&d)|(c&d), K = 8F1BBCDC.
      - t 60-79: f = b^c^d, K = CA62C1D6.
    - Update: temp = rotl5(a)+f+e+K+W[t] mod 2^32; then e=d, d=c, c=rotl30(b), b=a, a=temp.
    - loop_idx increments after each round. At t=79, loop_idx holds 79 and state → FINAL.
  - FINAL (edge k+81): digest_out[i] = H[i] + {a,b,c,d,e}[i], each 32-bit lane mod 2^32; state → DONE.
  - DONE: done = 1 from edge k+82 onward; digest_out held stable.
    - start=0 → IDLE; done stays 1 until the next block starts.
    - start still 1: remain in DONE; no restart.
- Latency: done observed high 82 cycles after the edge that sampled start.
- Abort: start=0 during ROUND or FINAL → IDLE next edge, with panic=1 (sticky), done=0 and digest_out unchanged.
  - panic clears on the next accepted start, or on reset/soft_reset.
- Changes to message_in or chain after the start edge are ignored; the block is fully captured at start.
- soft_reset and start high in the same cycle: the reset wins and the core ends in IDLE. It starts on the following cycle if start is still high.
- All additions wrap at 32 bits; no carries cross lanes.

Test Plan:
- "abc" block (W0=61626380, W1..W14=0, W15=00000018), chain=0, start held → done rises exactly 82 cycles later. digest_out[31:0]=A9993E36, [63:32]=4706816A, [95:64]=BA3E2571, [127:96]=7850C26C, [159:128]=9CD0D89D. loop_idx sweeps 0..79 one per cycle.
- Empty message (W0=80000000, rest 0) → DA39A3EE 5E6B4B0D 3255BFEF 95601890 AFD80709 in H0..H4 order.
- Two-block NIST message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 (56 message bytes + 80000000 + 00000000) with chain=0.
  - Drop start, then block 2 (zeros, W15=000001C0) with chain=1.
  - Required result: 84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1.
- Deassert start at loop_idx=40 → IDLE next cycle, panic=1, done=0, digest_out unchanged. A new start clears panic, and a full run gives the correct digest.
- soft_reset pulse mid-ROUND, and separately in DONE → next cycle digest_out=0, done=0, panic=0, loop_idx=0.
- Hold start high after done → no second computation and digest stable for 200 cycles. Change message_in mid-run → result still matches the block captured at the start edge.

Source files
------------

// File: rtl/sha1_core.sv
// Iterative SHA-1 compression engine: one round per clock, 80 rounds plus a
// finalisation cycle. Supports chaining from the current digest for multi-block messages.
module sha1_core #(
    parameter logic [159:0] IV = 160'hC3D2E1F0_10325476_98BADCFE_EFCDAB89_67452301
) (
    input  logic         wb_clk_i,
    input  logic         reset,
    input  logic         soft_reset,
    input  logic         start,
    input  logic         chain,
    input  logic [511:0] message_in,
    output logic [159:0] digest_out,
    output logic         done,
    output logic         panic,
    output logic [6:0]   loop_idx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [31:0]  a_q, b_q, c_q, d_q, e_q;
    logic [31:0]  a_d, b_d, c_d, d_d, e_d;
    logic [159:0] h_q, h_d;
    logic [159:0] digest_q, digest_d;
    logic         done_q, done_d;
    logic         panic_q, panic_d;
    logic [6:0]   idx_q, idx_d;

    logic [3:0]   t4;
    logic [31:0]  w_new, w_t, f, k, temp;
    logic [159:0] h_init;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    // The schedule lives in a 16-word ring; 4-bit index arithmetic gives the mod-16 wrap.
    always_comb begin
        t4    = idx_q[3:0];
        w_new = rotl1(w_q[t4 - 4'd3] ^ w_q[t4 - 4'd8] ^ w_q[t4 - 4'd14] ^ w_q[t4]);
        w_t   = (idx_q < 7'd16) ? w_q[t4] : w_new;
        if (idx_q < 7'd20) begin
            f = (b_q & c_q) | (~b_q & d_q);
            k = 32'h5A827999;
        end else if (idx_q < 7'd40) begin
            f = b_q ^ c_q ^ d_q;
            k = 32'h6ED9EBA1;
        end else if (idx_q < 7'd60) begin
            f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
            k = 32'h8F1BBCDC;
        end else begin
            f = b_q ^ c_q ^ d_q;
            k = 32'hCA62C1D6;
        end
        temp   = rotl5(a_q) + f + e_q + k + w_t;
        h_init = chain ? digest_q : IV;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        e_d      = e_q;
        h_d      = h_q;
        digest_d = digest_q;
        done_d   = done_q;
        panic_d  = panic_q;
        idx_d    = idx_q;
        for (int i = 0; i < 16; i++) w_d[i] = w_q[i];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) w_d[i] = message_in[32*i +: 32];
                    a_d     = h_init[31:0];
                    b_d     = h_init[63:32];
                    c_d     = h_init[95:64];
                    d_d     = h_init[127:96];
                    e_d     = h_init[159:128];
                    h_d     = h_init;
                    idx_d   = 7'd0;
                    done_d  = 1'b0;
                    panic_d = 1'b0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (!start) begin
                    panic_d = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    e_d = d_q;
                    d_d = c_q;
                    c_d = rotl30(b_q);
                    b_d = a_q;
                    a_d = temp;
                    if (idx_q >= 7'd16) w_d[t4] = w_new;
                    if (idx_q == 7'd79) state_d = S_FINAL;
                    else                idx_d   = idx_q + 7'd1;
                end
            end
            S_FINAL: begin
                if (!start) begin
                    panic_d = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    digest_d = {h_q[159:128] + e_q, h_q[127:96] + d_q, h_q[95:64] + c_q,
                                h_q[63:32] + b_q, h_q[31:0] + a_q};
                    state_d  = S_DONE;
                end
            end
            default: begin
                done_d = 1'b1;
                if (!start) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset || soft_reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            e_q      <= '0;
            h_q      <= '0;
            digest_q <= '0;
            done_q   <= 1'b0;
            panic_q  <= 1'b0;
            idx_q    <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            e_q      <= e_d;
            h_q      <= h_d;
            digest_q <= digest_d;
            done_q   <= done_d;
            panic_q  <= panic_d;
            idx_q    <= idx_d;
            for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
        end
    end

    assign digest_out = digest_q;
    assign done       = done_q;
    assign panic      = panic_q;
    assign loop_idx   = idx_q;

endmodule

// File: tb/tb_sha1_core.sv
// Bench for sha1_core: known-answer vectors, randomized blocks against a
// straightforward SHA-1 model, plus abort, soft-reset and hold sequences.
module tb_sha1_core;

    localparam logic [159:0] IV_TB = 160'hC3D2E1F0_10325476_98BADCFE_EFCDAB89_67452301;

    logic         wb_clk_i;
    logic         reset;
    logic         soft_reset;
    logic         start;
    logic         chain;
    logic [511:0] message_in;
    logic [159:0] digest_out;
    logic         done;
    logic         panic;
    logic [6:0]   loop_idx;

    int total = 0;
    int bad   = 0;
    logic [159:0] model_dig;

    typedef struct {
        string        name;
        logic [511:0] msg;
        logic         chn;
        logic         has_exp;
        logic [159:0] exp;
    } vec_t;

    vec_t vecs[4];

    sha1_core dut (
        .wb_clk_i   (wb_clk_i),
        .reset      (reset),
        .soft_reset (soft_reset),
        .start      (start),
        .chain      (chain),
        .message_in (message_in),
        .digest_out (digest_out),
        .done       (done),
        .panic      (panic),
        .loop_idx   (loop_idx)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Textbook SHA-1 compression with a full 80-word expanded schedule.
    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = m[32*t +: 32];
        for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
        a = h[31:0]; b = h[63:32]; c = h[95:64]; d = h[127:96]; e = h[159:128];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = rol(a, 5) + f + e + k + w[t];
            e = d; d = c; c = rol(b, 30); b = a; a = tmp;
        end
        return {h[159:128] + e, h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_digest"}, digest_out, 160'd0);
        chk({nm, "_done"}, 160'(done), 160'd0);
        chk({nm, "_panic"}, 160'(panic), 160'd0);
        chk({nm, "_idx"}, 160'(loop_idx), 160'd0);
    endtask

    // Starts one block, checks latency, loop_idx sweep and panic clear; optionally
    // holds start after done and checks the digest stays put.
    task automatic run_block(input string nm, input logic [511:0] msg, input logic chn,
                             input logic scramble, input int hold_cycles, input logic drop,
                             output logic [159:0] got);
        int   cyc;
        int   exp_idx;
        logic sweep_ok;
        logic stable_ok;
        @(negedge wb_clk_i);
        message_in = msg;
        chain      = chn;
        start      = 1'b1;
        @(posedge wb_clk_i); #1;
        chk({nm, "_panic_clr"}, 160'(panic), 160'd0);
        sweep_ok = (loop_idx == 7'd0) && !done;
        cyc = 0;
        while (1) begin
            @(posedge wb_clk_i); #1;
            cyc++;
            if (done || cyc >= 150) break;
            exp_idx = (cyc > 79) ? 79 : cyc;
            if (loop_idx != 7'(exp_idx)) sweep_ok = 1'b0;
            if (scramble) begin
                message_in = rand512();
                chain      = 1'($urandom);
            end
        end
        chk({nm, "_latency"}, 160'(cyc), 160'd82);
        chk({nm, "_sweep"}, 160'(sweep_ok), 160'd1);
        got = digest_out;
        if (hold_cycles > 0) begin
            stable_ok = 1'b1;
            for (int i = 0; i < hold_cycles; i++) begin
                @(posedge wb_clk_i); #1;
                if (digest_out !== got || done !== 1'b1) stable_ok = 1'b0;
            end
            chk({nm, "_hold"}, 160'(stable_ok), 160'd1);
        end
        if (drop) begin
            @(negedge wb_clk_i);
            start = 1'b0;
            @(posedge wb_clk_i); #1;
        end
    endtask

    initial begin
        logic [511:0] m;
        logic [159:0] got;
        logic [159:0] exp;
        logic [31:0]  b1w [16];
        logic         c;
        int           n;

        reset = 1'b1; soft_reset = 1'b0; start = 1'b0; chain = 1'b0; message_in = '0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk_cleared("reset");
        @(negedge wb_clk_i);
        reset = 1'b0;
        model_dig = '0;

        // Known-answer vectors.
        m = '0; m[31:0] = 32'h61626380; m[511:480] = 32'h00000018;
        vecs[0] = '{"abc", m, 1'b0, 1'b1,
                    {32'h9CD0D89D, 32'h7850C26C, 32'hBA3E2571, 32'h4706816A, 32'hA9993E36}};
        m = '0; m[31:0] = 32'h80000000;
        vecs[1] = '{"empty", m, 1'b0, 1'b1,
                    {32'hAFD80709, 32'h95601890, 32'h3255BFEF, 32'h5E6B4B0D, 32'hDA39A3EE}};
        b1w = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 16; i++) m[32*i +: 32] = b1w[i];
        vecs[2] = '{"nist2_b1", m, 1'b0, 1'b0, 160'd0};
        m = '0; m[511:480] = 32'h000001C0;
        vecs[3] = '{"nist2_b2", m, 1'b1, 1'b1,
                    {32'hE54670F1, 32'hF95129E5, 32'hBAAE4AA1, 32'h1C3BD26E, 32'h84983E44}};

        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].name, vecs[i].msg, vecs[i].chn, 1'b0, 0, 1'b1, got);
            exp = vecs[i].has_exp ? vecs[i].exp
                                  : sha1_compress(vecs[i].chn ? model_dig : IV_TB, vecs[i].msg);
            chk({vecs[i].name, "_digest"}, got, exp);
            model_dig = exp;
        end

        // Random blocks, some with inputs scrambled after the start edge.
        for (int i = 0; i < 6; i++) begin
            m = rand512();
            c = 1'($urandom);
            exp = sha1_compress(c ? model_dig : IV_TB, m);
            run_block($sformatf("rand%0d", i), m, c, 1'(i % 2), 0, 1'b1, got);
            chk($sformatf("rand%0d_digest", i), got, exp);
            model_dig = exp;
        end

        // Abort at round 40.
        @(negedge wb_clk_i);
        message_in = rand512(); chain = 1'b0; start = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (loop_idx != 7'd40 && n < 200);
        chk("abort_reach", 160'(loop_idx), 160'd40);
        start = 1'b0;
        @(posedge wb_clk_i); #1;
        chk("abort_panic", 160'(panic), 160'd1);
        chk("abort_done", 160'(done), 160'd0);
        chk("abort_digest", digest_out, model_dig);
        m = rand512();
        exp = sha1_compress(IV_TB, m);
        run_block("post_abort", m, 1'b0, 1'b0, 0, 1'b1, got);
        chk("post_abort_digest", got, exp);
        model_dig = exp;

        // Soft reset in the middle of the rounds.
        @(negedge wb_clk_i);
        message_in = rand512(); chain = 1'b1; start = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (loop_idx != 7'd30 && n < 200);
        soft_reset = 1'b1; start = 1'b0;
        @(posedge wb_clk_i); #1;
        soft_reset = 1'b0;
        chk_cleared("srst_round");
        model_dig = '0;

        // Chaining from the cleared digest, hold start after done, then soft reset in DONE.
        m = rand512();
        exp = sha1_compress(model_dig, m);
        run_block("hold", m, 1'b1, 1'b0, 200, 1'b0, got);
        chk("hold_digest", got, exp);
        @(negedge wb_clk_i);
        soft_reset = 1'b1; start = 1'b0;
        @(posedge wb_clk_i); #1;
        soft_reset = 1'b0;
        chk_cleared("srst_done");
        model_dig = '0;

        // Soft reset and start together: reset wins, start is taken the next cycle.
        m = vecs[0].msg;
        @(negedge wb_clk_i);
        message_in = m; chain = 1'b0; start = 1'b1; soft_reset = 1'b1;
        @(posedge wb_clk_i); #1;
        soft_reset = 1'b0;
        chk("srst_start_idx", 160'(loop_idx), 160'd0);
        run_block("after_srst", m, 1'b0, 1'b0, 0, 1'b1, got);
        chk("after_srst_digest", got, vecs[0].exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
